matmul_result_drain: RTL and testbench
======================================

Name: matmul_result_drain

Overview:
- Reader end of the matrix-multiplier result interface.
- When the multiplier raises finish_mul, this block snapshots the flattened C matrix and the overflow flags.
- It streams the valid N×M elements row-major, one word per transfer, onto a valid/ready scratchpad write port.
- It then pulses finish_write_o back to control, closing the finish_mul/finish_write loop.

Parameters:
- DATA_WIDTH, 8, operand element width. Used only to derive MAX_DIM.
- BUS_WIDTH, 16, result element width and write-data width.
- ADDR_WIDTH, 5, scratchpad word-address width.
- MAX_DIM, localparam BUS_WIDTH/DATA_WIDTH, maximum matrix dimension.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- finish_mul_i  in  1  multiplier done. Level; stays high until control drops start.
- c_matrix_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  flattened result. Element (r,c) is at bits [(r*MAX_DIM+c+1)*BUS_WIDTH-1 -: BUS_WIDTH].
- flags_i  in  MAX_DIM*MAX_DIM  per-PE overflow. Element (r,c) maps to bit r+c*MAX_DIM.
- n_dim_i  in  2  result rows minus 1.
- m_dim_i  in  2  result cols minus 1.
- base_addr_i  in  ADDR_WIDTH  destination address of element (0,0).
- wr_ready_i  in  1  scratchpad accepts a write this cycle.
- wr_en_o  out  1  write valid.
- wr_addr_o  out  ADDR_WIDTH  write address.
- wr_data_o  out  BUS_WIDTH  write data (signed element).
- flags_o  out  MAX_DIM*MAX_DIM  latched flags, masked to the valid region.
- overflow_o  out  1  OR of flags_o.
- busy_o  out  1  high in any state other than IDLE.
- finish_write_o  out  1  one-cycle done pulse.

Behaviour:
- Reset (async, rst_i=1): state IDLE. wr_en_o, wr_addr_o, wr_data_o, flags_o, overflow_o, busy_o and finish_write_o are all 0. Snapshot registers are cleared.
- Reset mid-drain aborts immediately. No finish_write_o is issued for the aborted drain, and no partial state survives.
- States: IDLE -> WRITE -> [FLAGS] -> DONE -> WAIT_REL -> IDLE.
- IDLE:
  - On a clock edge with finish_mul_i=1: capture c_matrix_i, n_dim_i, m_dim_i and base_addr_i.
  - Capture flags_i ANDed with the valid-region mask.
  - Clamp each dim to MAX_DIM-1.
  - Go to WRITE with row=0, col=0.
- WRITE:
  - wr_en_o=1.
  - wr_addr_o = base + row*MAX_DIM + col, modulo 2^ADDR_WIDTH (wrap-around permitted, not flagged).
  - wr_data_o = snapshot element (row,col).
  - Address and data are held stable until wr_en_o & wr_ready_i.
  - On a transfer edge: advance col. At col==m, reset col to 0 and advance row. At row==n and col==m, leave WRITE.
  - Throughput: one element per cycle while wr_ready_i stays high.
- First wr_en_o is asserted the cycle after the capture edge.
- Total transfers = (n+1)*(m+1), range 1 to MAX_DIM².
- DONE: finish_write_o=1 for exactly one cycle and wr_en_o=0. Unconditionally move to WAIT_REL.
- WAIT_REL: wait for finish_mul_i=0, then go to IDLE. This prevents re-triggering on the same finish_mul level.
- Inputs during a drain: changes to c_matrix_i, the dims or finish_mul_i while in WRITE/FLAGS are ignored; the snapshot governs.
- flags_o and overflow_o are updated at capture and hold until the next capture or reset.
- Latency with wr_ready_i tied high:
  - Capture at edge k.
  - Last element transfers at edge k+(n+1)(m+1).
  - finish_write_o is high in the following cycle (without the optional feature).

Optional Feature:
- Macro MATMUL_DRAIN_FLAGS_WORD_EN.
- When defined:
  - After the last element, the FLAGS state issues one extra write.
  - Address = base + MAX_DIM*MAX_DIM (wraps).
  - Data = flags_o zero-extended to BUS_WIDTH.
  - The write uses the same valid/ready rules; DONE follows its transfer.
- When undefined: the FLAGS state does not exist and WRITE goes directly to DONE.

Decomposition:
- Shared package matmul_pkg:
  - MAX_DIM derivation.
  - State encoding enum (IDLE, WRITE, FLAGS, DONE, WAIT_REL).
  - Element-offset function (r*MAX_DIM+c).
  - Flag-bit index function (r+c*MAX_DIM).
- One natural sub-module, matmul_drain_addr_gen: the row/col counter with clamp and terminal detect, producing the element index and last-flag.

Test Plan:
- Defaults, n=m=1, base=4, C={(0,0)=1,(0,1)=-2,(1,0)=3,(1,1)=0x7FFF}, ready=1 -> writes addr 4,5,6,7 with data 0x0001,0xFFFE,0x0003,0x7FFF on consecutive cycles. finish_write_o pulses the next cycle.
- n=0, m=1, flags_i=4'b1111 -> 2 writes (addr base, base+1). flags_o=4'b0101 (bits (0,0)=0 and (0,1)=2). overflow_o=1.
- wr_ready_i low for 3 cycles during the second element -> addr/data held constant, no skipped or duplicated writes, 4 total transfers.
- base=31, n=m=1 -> addresses 31,0,1,2 (wrap).
- rst_i asserted after 2 transfers -> all outputs 0 immediately, no finish_write_o. A new finish_mul_i restarts at (0,0).
- finish_mul_i held high after DONE -> no second drain until finish_mul_i=0 then 1. With MATMUL_DRAIN_FLAGS_WORD_EN, a 5th write at base+4 carries the flags.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and index helpers for the matrix-multiplier result drain.
package matmul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StFlags,
    StDone,
    StWaitRel
  } state_e;

  function automatic int unsigned max_dim_of(input int unsigned bus_width,
                                             input int unsigned data_width);
    return bus_width / data_width;
  endfunction

  // Row-major element offset within the flattened C matrix.
  function automatic int unsigned elem_offset(input int unsigned r, input int unsigned c,
                                              input int unsigned max_dim);
    return r * max_dim + c;
  endfunction

  // Overflow flags are stored column-major.
  function automatic int unsigned flag_index(input int unsigned r, input int unsigned c,
                                             input int unsigned max_dim);
    return r + c * max_dim;
  endfunction

  function automatic logic [1:0] clamp_dim(input logic [1:0] d, input int unsigned max_dim);
    if (32'(d) > max_dim - 1) begin
      return 2'(max_dim - 1);
    end
    return d;
  endfunction

endpackage

// File: rtl/matmul_drain_addr_gen.sv
// Row/column walker for the result drain: clamps dims at load, produces element index and
// last-element flag, advances one element per accepted write.
module matmul_drain_addr_gen
  import matmul_pkg::*;
#(
  parameter int unsigned MAX_DIM = 2,
  parameter int unsigned IDX_W   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [1:0]       n_dim_i,
  input  logic [1:0]       m_dim_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [1:0] r_row;
  logic [1:0] r_col;
  logic [1:0] r_n;
  logic [1:0] r_m;
  logic       w_last;

  assign w_last = (r_row == r_n) && (r_col == r_m);
  assign last_o = w_last;
  assign idx_o  = IDX_W'(elem_offset(32'(r_row), 32'(r_col), MAX_DIM));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_row <= '0;
      r_col <= '0;
      r_n   <= '0;
      r_m   <= '0;
    end else if (load_i) begin
      r_row <= '0;
      r_col <= '0;
      r_n   <= clamp_dim(n_dim_i, MAX_DIM);
      r_m   <= clamp_dim(m_dim_i, MAX_DIM);
    end else if (adv_i) begin
      if (r_col == r_m) begin
        r_col <= '0;
        r_row <= w_last ? 2'd0 : r_row + 2'd1;
      end else begin
        r_col <= r_col + 2'd1;
      end
    end
  end

endmodule

// File: rtl/matmul_result_drain.sv
// Snapshots the multiplier result on finish_mul and streams it row-major to the scratchpad.
// Define MATMUL_DRAIN_FLAGS_WORD_EN to append one write carrying the overflow flags.
module matmul_result_drain
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  localparam int unsigned MAX_DIM   = max_dim_of(BUS_WIDTH, DATA_WIDTH),
  localparam int unsigned NUM_EL    = MAX_DIM * MAX_DIM
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        finish_mul_i,
  input  logic [NUM_EL*BUS_WIDTH-1:0] c_matrix_i,
  input  logic [NUM_EL-1:0]           flags_i,
  input  logic [1:0]                  n_dim_i,
  input  logic [1:0]                  m_dim_i,
  input  logic [ADDR_WIDTH-1:0]       base_addr_i,
  input  logic                        wr_ready_i,
  output logic                        wr_en_o,
  output logic [ADDR_WIDTH-1:0]       wr_addr_o,
  output logic [BUS_WIDTH-1:0]        wr_data_o,
  output logic [NUM_EL-1:0]           flags_o,
  output logic                        overflow_o,
  output logic                        busy_o,
  output logic                        finish_write_o
);

  localparam int unsigned IDX_W = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;

  state_e                      r_state;
  state_e                      w_state_next;
  logic [NUM_EL*BUS_WIDTH-1:0] r_cmat;
  logic [ADDR_WIDTH-1:0]       r_base;
  logic [NUM_EL-1:0]           r_flags;
  logic [NUM_EL-1:0]           w_flag_mask;
  logic                        w_capture;
  logic                        w_xfer;
  logic                        w_last;
  logic [IDX_W-1:0]            w_idx;

  assign w_capture = (r_state == StIdle) && finish_mul_i;
  assign w_xfer    = (r_state == StWrite) && wr_ready_i;

  matmul_drain_addr_gen #(
    .MAX_DIM (MAX_DIM),
    .IDX_W   (IDX_W)
  ) u_addr_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_capture),
    .adv_i   (w_xfer),
    .n_dim_i (n_dim_i),
    .m_dim_i (m_dim_i),
    .idx_o   (w_idx),
    .last_o  (w_last)
  );

  // Rows/cols beyond MAX_DIM-1 do not exist, so comparing against the raw dims equals the clamp.
  always_comb begin
    w_flag_mask = '0;
    for (int unsigned r = 0; r < MAX_DIM; r++) begin
      for (int unsigned c = 0; c < MAX_DIM; c++) begin
        w_flag_mask[flag_index(r, c, MAX_DIM)] = (r <= 32'(n_dim_i)) && (c <= 32'(m_dim_i));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cmat  <= '0;
      r_base  <= '0;
      r_flags <= '0;
    end else if (w_capture) begin
      r_cmat  <= c_matrix_i;
      r_base  <= base_addr_i;
      r_flags <= flags_i & w_flag_mask;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (finish_mul_i) w_state_next = StWrite;
      end
      StWrite: begin
        if (w_xfer && w_last) begin
`ifdef MATMUL_DRAIN_FLAGS_WORD_EN
          w_state_next = StFlags;
`else
          w_state_next = StDone;
`endif
        end
      end
      StFlags: begin
        if (wr_ready_i) w_state_next = StDone;
      end
      StDone: begin
        w_state_next = StWaitRel;
      end
      StWaitRel: begin
        if (!finish_mul_i) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    wr_en_o        = 1'b0;
    wr_addr_o      = '0;
    wr_data_o      = '0;
    finish_write_o = 1'b0;
    busy_o         = (r_state != StIdle);
    unique case (r_state)
      StWrite: begin
        wr_en_o   = 1'b1;
        wr_addr_o = r_base + ADDR_WIDTH'(w_idx);
        wr_data_o = r_cmat[w_idx*BUS_WIDTH +: BUS_WIDTH];
      end
`ifdef MATMUL_DRAIN_FLAGS_WORD_EN
      StFlags: begin
        wr_en_o   = 1'b1;
        wr_addr_o = r_base + ADDR_WIDTH'(NUM_EL);
        wr_data_o = BUS_WIDTH'(r_flags);
      end
`endif
      StDone: begin
        finish_write_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign flags_o    = r_flags;
  assign overflow_o = |r_flags;

endmodule

// File: tb/tb_matmul_result_drain.sv
// Self-checking bench for matmul_result_drain: table vectors, hand sequences and random drains
// compared against an element-list reference model.
module tb_matmul_result_drain;

  localparam int MD = 2;
  localparam int NE = MD * MD;
  localparam int BW = 16;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              finish_mul_i;
  logic [NE*BW-1:0]  c_matrix_i;
  logic [NE-1:0]     flags_i;
  logic [1:0]        n_dim_i;
  logic [1:0]        m_dim_i;
  logic [AW-1:0]     base_addr_i;
  logic              wr_ready_i;
  logic              wr_en_o;
  logic [AW-1:0]     wr_addr_o;
  logic [BW-1:0]     wr_data_o;
  logic [NE-1:0]     flags_o;
  logic              overflow_o;
  logic              busy_o;
  logic              finish_write_o;

  matmul_result_drain dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .finish_mul_i   (finish_mul_i),
    .c_matrix_i     (c_matrix_i),
    .flags_i        (flags_i),
    .n_dim_i        (n_dim_i),
    .m_dim_i        (m_dim_i),
    .base_addr_i    (base_addr_i),
    .wr_ready_i     (wr_ready_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .flags_o        (flags_o),
    .overflow_o     (overflow_o),
    .busy_o         (busy_o),
    .finish_write_o (finish_write_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [28:0] out_vec();
    return {wr_en_o, wr_addr_o, wr_data_o, flags_o, overflow_o, busy_o, finish_write_o};
  endfunction

  // Reference: the set of valid elements and which flags survive masking.
  function automatic logic [NE-1:0] model_flags(input logic [1:0] n, input logic [1:0] m,
                                                input logic [NE-1:0] fl);
    logic [NE-1:0] res = '0;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        if (r <= int'(n) && c <= int'(m)) res[r + c*MD] = fl[r + c*MD];
    return res;
  endfunction

  function automatic int model_count(input logic [1:0] n, input logic [1:0] m);
    int rows = (int'(n) >= MD) ? MD : int'(n) + 1;
    int cols = (int'(m) >= MD) ? MD : int'(m) + 1;
    return rows * cols;
  endfunction

  // Caller sits at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_drain(input string tag, input logic [1:0] n, input logic [1:0] m,
                           input logic [AW-1:0] base, input logic [NE*BW-1:0] cm,
                           input logic [NE-1:0] fl, input int mode, input int exp_w,
                           input logic [NE-1:0] exp_fl, input logic exp_ovf);
    logic [AW-1:0] qa[$];
    logic [BW-1:0] qd[$];
    logic [AW-1:0] hold_a;
    logic [BW-1:0] hold_d;
    logic          have_hold = 1'b0;
    logic          rdy;
    int            xfers = 0;
    int            stall = 0;
    int            iter = 0;
    int            fin_iter = 0;
    bit            done = 0;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        if (r <= int'(n) && c <= int'(m)) begin
          qa.push_back(AW'(int'(base) + r*MD + c));
          qd.push_back(cm[(r*MD + c)*BW +: BW]);
        end
    c_matrix_i   = cm;
    flags_i      = fl;
    n_dim_i      = n;
    m_dim_i      = m;
    base_addr_i  = base;
    finish_mul_i = 1'b1;
    while (!done && iter < 200) begin
      @(negedge clk);
      iter++;
      if (iter == 1) begin
        c_matrix_i  = ~cm;
        flags_i     = ~fl;
        n_dim_i     = ~n;
        m_dim_i     = ~m;
        base_addr_i = base + 5'd7;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(xfers == 1 && stall < 3);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      if (!rdy && mode == 1) stall++;
      wr_ready_i = rdy;
      #1;
      if (mode == 0 && iter == 1) check({tag, " first_wr_en"}, 64'(wr_en_o), 64'd1);
      if (have_hold) begin
        check({tag, " hold"}, {wr_en_o, wr_addr_o, wr_data_o}, {1'b1, hold_a, hold_d});
        have_hold = 1'b0;
      end
      if (finish_write_o) begin
        done     = 1;
        fin_iter = iter;
        check({tag, " done_no_wr"}, 64'(wr_en_o), 64'd0);
      end else if (wr_en_o) begin
        if (rdy) begin
          if (qa.size() == 0) begin
            check({tag, " extra_write"}, 64'(wr_addr_o), 64'h1_0000);
          end else begin
            check({tag, " wr_addr"}, 64'(wr_addr_o), 64'(qa.pop_front()));
            check({tag, " wr_data"}, 64'(wr_data_o), 64'(qd.pop_front()));
          end
          xfers++;
        end else begin
          hold_a    = wr_addr_o;
          hold_d    = wr_data_o;
          have_hold = 1'b1;
        end
      end
    end
    check({tag, " finished"}, 64'(done), 64'd1);
    check({tag, " xfers"}, 64'(xfers), 64'(exp_w));
    check({tag, " model_left"}, 64'(qa.size()), 64'd0);
    if (mode == 0) check({tag, " latency"}, 64'(fin_iter), 64'(exp_w + 1));
    check({tag, " flags_o"}, 64'(flags_o), 64'(exp_fl));
    check({tag, " overflow_o"}, 64'(overflow_o), 64'(exp_ovf));
    // Held finish_mul must not retrigger.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check({tag, " wait_rel"}, {finish_write_o, wr_en_o, busy_o}, 3'b001);
    end
    finish_mul_i = 1'b0;
    wr_ready_i   = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " idle_after"}, 64'(busy_o), 64'd0);
  endtask

  typedef struct {
    logic [1:0]       n;
    logic [1:0]       m;
    logic [AW-1:0]    base;
    logic [NE*BW-1:0] cm;
    logic [NE-1:0]    fl;
    int               mode;
    int               exp_w;
    logic [NE-1:0]    exp_fl;
    logic             exp_ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{2'd1, 2'd1, 5'd4,  64'h7FFF_0003_FFFE_0001, 4'b0000, 0, 4, 4'b0000, 1'b0};
    tbl[1] = '{2'd0, 2'd1, 5'd10, 64'h1111_2222_3333_4444, 4'b1111, 0, 2, 4'b0101, 1'b1};
    tbl[2] = '{2'd1, 2'd1, 5'd12, 64'hAAAA_BBBB_CCCC_DDDD, 4'b1000, 1, 4, 4'b1000, 1'b1};
    tbl[3] = '{2'd1, 2'd1, 5'd31, 64'h0004_0003_0002_0001, 4'b0000, 0, 4, 4'b0000, 1'b0};
    tbl[4] = '{2'd3, 2'd3, 5'd20, 64'h8000_7FFF_0102_FEDC, 4'b1111, 2, 4, 4'b1111, 1'b1};
    tbl[5] = '{2'd1, 2'd0, 5'd2,  64'h5555_6666_7777_8888, 4'b1111, 0, 2, 4'b0011, 1'b1};

    rst_i        = 1'b1;
    finish_mul_i = 1'b0;
    c_matrix_i   = '0;
    flags_i      = '0;
    n_dim_i      = '0;
    m_dim_i      = '0;
    base_addr_i  = '0;
    wr_ready_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(out_vec()), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    #1;
    check("idle_outputs", 64'(out_vec()), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_drain($sformatf("vec%0d", i), tbl[i].n, tbl[i].m, tbl[i].base, tbl[i].cm, tbl[i].fl,
                tbl[i].mode, tbl[i].exp_w, tbl[i].exp_fl, tbl[i].exp_ovf);
    end

    // Reset after two transfers aborts without a done pulse.
    c_matrix_i   = 64'h0D0D_0C0C_0B0B_0A0A;
    flags_i      = 4'b1111;
    n_dim_i      = 2'd1;
    m_dim_i      = 2'd1;
    base_addr_i  = 5'd8;
    wr_ready_i   = 1'b1;
    finish_mul_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i        = 1'b1;
    finish_mul_i = 1'b0;
    #1;
    check("abort_outputs", 64'(out_vec()), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", 64'(finish_write_o), 64'd0);
    end
    rst_i = 1'b0;
    @(negedge clk);
    run_drain("restart", 2'd1, 2'd1, 5'd8, 64'h0D0D_0C0C_0B0B_0A0A, 4'b0110, 0, 4, 4'b0110,
              1'b1);

    for (int i = 0; i < 20; i++) begin
      logic [1:0]       n;
      logic [1:0]       m;
      logic [AW-1:0]    base;
      logic [NE*BW-1:0] cm;
      logic [NE-1:0]    fl;
      logic [NE-1:0]    efl;
      n    = 2'($urandom_range(0, 3));
      m    = 2'($urandom_range(0, 3));
      base = AW'($urandom);
      cm   = {$urandom, $urandom};
      fl   = NE'($urandom);
      efl  = model_flags(n, m, fl);
      run_drain($sformatf("rnd%0d", i), n, m, base, cm, fl, (i % 3 == 0) ? 0 : 2,
                model_count(n, m), efl, |efl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
